fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
Instruction buffer on the receive side of the fetch→decode valid/ready interface. It accepts {instr, pc} pairs from fetch, stores them in an in-order circular FIFO, and presents them to decode through a second valid/ready handshake. A flush (branch redirect) discards every buffered wrong-path entry in one cycle. It decouples fetch from decode backpressure so fetch stalls only when the queue is full.

Parameters:
DEPTH, 4, number of entries; power of 2, ≥2
XLEN, 32, width of instr and pc

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
flush  input  1  branch redirect; discard all buffered entries
in_valid  input  1  fetch presents a valid instr/pc
in_ready  output  1  queue can accept an entry this cycle
in_instr  input  XLEN  instruction from fetch
in_pc  input  XLEN  pc of in_instr
out_valid  output  1  head entry valid for decode
out_ready  input  1  decode accepts head entry this cycle
out_instr  output  XLEN  head instruction
out_pc  output  XLEN  head pc
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH

Behaviour:
- State: storage array[DEPTH] of {instr, pc}; head and tail pointers ($clog2(DEPTH) bits, wrap modulo DEPTH); count register.
- Reset (sync, active-high): head=0, tail=0, count=0. The storage array is not reset. While reset is high: in_ready=0, out_valid=0.
- in_ready = !reset && (count != DEPTH). It depends only on state, with no combinational path from out_ready. A full queue does not accept a push, even in a cycle where it pops.
- out_valid = !reset && !flush && (count != 0).
- out_instr/out_pc = storage[head] when count != 0; drive 0 when empty.
- Push = in_valid && in_ready && !flush. On push: storage[tail] ← {in_instr, in_pc}, tail ← tail+1.
- Pop = out_valid && out_ready. On pop: head ← head+1.
- count updates next cycle: +1 on push only, −1 on pop only, unchanged when both occur.
- Latency: no bypass. An entry pushed in cycle N is first visible at the output in cycle N+1, even when the queue was empty.
- Simultaneous push and pop with 0<count<DEPTH: both occur and count is unchanged.
- Flush has priority over everything else:
  - In the flush cycle, push and pop are both suppressed.
  - Next cycle: head=tail=0 and count=0.
  - In the flush cycle, out_valid is forced to 0 so decode cannot consume a wrong-path entry.
  - in_ready still reflects pre-flush count, but the offered entry is dropped.
- Flush and reset together: reset wins; the result is identical.
- Pointer wrap: DEPTH−1 → 0, with no bubble.
- FIFO order is strictly preserved. Entries are never duplicated or dropped, except by flush or reset.

Test Plan:
- Fill then drain, DEPTH=4:
  - Push pc 0x0,0x4,0x8,0xC with out_ready=0 → count=4, in_ready=0.
  - Fifth offer (pc 0x10) held off and not stored.
  - Then raise out_ready → out_pc sequence 0x0,0x4,0x8,0xC on consecutive cycles, then out_valid=0 and count=0.
- Latency on empty queue: push instr 0x00000013 pc 0x100 at cycle N → out_valid=0 at N, out_valid=1 with out_pc=0x100 at N+1.
- Streaming with wrap:
  - Hold in_valid=1 and out_ready=1 for 12 cycles, pcs incrementing by 4 from 0x0.
  - Required: count stays at 1 after the first cycle, output pcs stay in order across pointer wrap, no gaps.
- Flush mid-stream:
  - With 3 entries (0x20,0x24,0x28), assert flush with in_valid=1 (pc 0x2C) and out_ready=1.
  - Required: out_valid=0 in the flush cycle; next cycle count=0 and out_valid=0.
  - Then push pc 0x400 → out_pc=0x400 one cycle later.
- Full plus pop: at count=4, in_valid=1 and out_ready=1 → pop occurs, push is refused (in_ready=0), count=3 next cycle.
- Reset mid-operation:
  - Assert reset with count=2 and in_valid=1 → in_ready=0 and out_valid=0 during reset; count=0 after.
  - First post-reset push (pc 0x0) appears at the output one cycle later.

Source files
------------

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : In-order circular instruction buffer between fetch and decode,
//               with valid/ready on both sides and single-cycle flush.
// Revision    : 1.0
// ============================================================================
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [XLEN-1:0]            in_instr,
    input  logic [XLEN-1:0]            in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_instr,
    output logic [XLEN-1:0]            out_pc,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

    logic [XLEN-1:0]  mem_instr_q [DEPTH];
    logic [XLEN-1:0]  mem_pc_q    [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             w_push;
    logic             w_pop;
    logic             w_empty;

    assign w_empty   = (count_q == '0);
    // in_ready is a pure function of state: no path from out_ready
    assign in_ready  = !reset && (count_q != C_FULL);
    assign out_valid = !reset && !flush && !w_empty;
    assign w_push    = in_valid && in_ready && !flush;
    assign w_pop     = out_valid && out_ready;

    assign out_instr = w_empty ? '0 : mem_instr_q[head_q];
    assign out_pc    = w_empty ? '0 : mem_pc_q[head_q];
    assign count     = count_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (w_push) tail_d = tail_q + PTR_W'(1);
            if (w_pop)  head_d = head_q + PTR_W'(1);
            if (w_push && !w_pop)
                count_d = count_q + CNT_W'(1);
            else if (w_pop && !w_push)
                count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is deliberately left unreset; occupancy gates all reads
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_instr_q[tail_q] <= in_instr;
            mem_pc_q[tail_q]    <= in_pc;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_queue
// Description : Self-checking bench for fetch_queue: queue-based reference
//               model checked every cycle, plus directed literal checks.
// Revision    : 1.0
// ============================================================================
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic              clk = 1'b0;
    logic              reset, flush, in_valid, out_ready;
    logic [XLEN-1:0]   in_instr, in_pc;
    logic              in_ready, out_valid;
    logic [XLEN-1:0]   out_instr, out_pc;
    logic [2:0]        count;

    int total = 0;
    int bad   = 0;

    fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of {instr, pc}
    logic [63:0] mq[$];

    always @(negedge clk) begin
        logic       e_ir, e_ov, do_pop, do_push;
        logic [31:0] e_instr, e_pc;
        e_ir    = !reset && (mq.size() != DEPTH);
        e_ov    = !reset && !flush && (mq.size() != 0);
        e_instr = (mq.size() != 0) ? mq[0][63:32] : 32'h0;
        e_pc    = (mq.size() != 0) ? mq[0][31:0]  : 32'h0;
        chk("m_in_ready",  {31'b0, in_ready},  {31'b0, e_ir});
        chk("m_out_valid", {31'b0, out_valid}, {31'b0, e_ov});
        chk("m_count",     {29'b0, count},     32'(mq.size()));
        chk("m_out_instr", out_instr, e_instr);
        chk("m_out_pc",    out_pc,    e_pc);
        if (reset || flush) begin
            mq.delete();
        end else begin
            do_pop  = e_ov && out_ready;
            do_push = in_valid && e_ir;
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back({in_instr, in_pc});
        end
    end

    task automatic drive(input logic r, input logic f, input logic iv,
                         input logic [31:0] pc, input logic ordy);
        reset     = r;
        flush     = f;
        in_valid  = iv;
        in_pc     = pc;
        in_instr  = pc ^ 32'hA5A5_0000;
        out_ready = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1, 0, 0, 0, 0);
        in_instr = 32'h0;
        tick(); tick();
        #1;
        chk("rst_count", {29'b0, count}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);

        // Fill then drain
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1, 32'(i * 4), 0);
            tick();
        end
        drive(0, 0, 1, 32'h10, 0);
        #1;
        chk("fill_count", {29'b0, count}, 32'd4);
        chk("fill_in_ready", {31'b0, in_ready}, 32'd0);
        tick();
        chk("fill_hold_count", {29'b0, count}, 32'd4);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 1);
            #1;
            chk("drain_valid", {31'b0, out_valid}, 32'd1);
            chk("drain_pc", out_pc, 32'(i * 4));
            tick();
        end
        #1;
        chk("drain_empty_valid", {31'b0, out_valid}, 32'd0);
        chk("drain_empty_count", {29'b0, count}, 32'd0);

        // Latency on empty queue
        drive(0, 0, 1, 32'h100, 1);
        in_instr = 32'h0000_0013;
        #1;
        chk("lat_valid_n", {31'b0, out_valid}, 32'd0);
        tick();
        drive(0, 0, 0, 0, 1);
        #1;
        chk("lat_valid_n1", {31'b0, out_valid}, 32'd1);
        chk("lat_pc", out_pc, 32'h100);
        chk("lat_instr", out_instr, 32'h0000_0013);
        tick();

        // Streaming across pointer wrap
        for (int i = 0; i < 12; i++) begin
            drive(0, 0, 1, 32'(i * 4), 1);
            #1;
            if (i > 0) begin
                chk("stream_count", {29'b0, count}, 32'd1);
                chk("stream_pc", out_pc, 32'((i - 1) * 4));
            end
            tick();
        end
        drive(0, 0, 0, 0, 1);
        tick();

        // Flush mid-stream
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 32'h20 + 32'(i * 4), 0);
            tick();
        end
        drive(0, 1, 1, 32'h2C, 1);
        #1;
        chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
        chk("flush_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        drive(0, 0, 0, 0, 1);
        #1;
        chk("flush_count", {29'b0, count}, 32'd0);
        chk("flush_after_valid", {31'b0, out_valid}, 32'd0);
        drive(0, 0, 1, 32'h400, 1);
        tick();
        drive(0, 0, 0, 0, 1);
        #1;
        chk("post_flush_pc", out_pc, 32'h400);
        tick();

        // Full plus pop: pop happens, push refused
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1, 32'h500 + 32'(i * 4), 0);
            tick();
        end
        drive(0, 0, 1, 32'h600, 1);
        #1;
        chk("fullpop_in_ready", {31'b0, in_ready}, 32'd0);
        chk("fullpop_out_valid", {31'b0, out_valid}, 32'd1);
        tick();
        drive(0, 0, 0, 0, 0);
        #1;
        chk("fullpop_count", {29'b0, count}, 32'd3);
        chk("fullpop_pc", out_pc, 32'h504);

        // Reset mid-operation at count=2
        drive(0, 0, 0, 0, 1);
        tick();
        drive(1, 0, 1, 32'h700, 0);
        #1;
        chk("midrst_count_before", {29'b0, count}, 32'd2);
        chk("midrst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        tick();
        drive(0, 0, 0, 0, 0);
        #1;
        chk("midrst_count_after", {29'b0, count}, 32'd0);
        drive(0, 0, 1, 32'h0, 0);
        tick();
        drive(0, 0, 0, 0, 1);
        #1;
        chk("postrst_valid", {31'b0, out_valid}, 32'd1);
        chk("postrst_pc", out_pc, 32'h0);
        tick();

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom % 64) == 0, ($urandom % 16) == 0, $urandom % 3 != 0,
                  $urandom, $urandom % 2 == 0);
            tick();
        end
        drive(0, 0, 0, 0, 0);
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
